// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch-port, data-port and unified-memory signals around the arbiter.
//   slave  : arbiter view (takes pipeline requests and memory read data, drives the rest)
//   master : environment view (pipeline front end, load/store unit and memory model)
// Inst side : inst_req_i, inst_addr_i, flush_i -> inst_rdata_o, inst_valid_o, inst_stall_o
// Data side : data_req_i, data_we_i, data_addr_i, data_wdata_i
//             -> data_rdata_o, data_valid_o, data_stall_o
// Memory    : mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o <- mem_rdata_i
interface mem_port_arbiter_if #(
    parameter int unsigned WORD_BITWIDTH = 32,
    parameter int unsigned ADDR_BITWIDTH = 32
);
    logic                     inst_req_i;
    logic [ADDR_BITWIDTH-1:0] inst_addr_i;
    logic                     flush_i;
    logic [WORD_BITWIDTH-1:0] inst_rdata_o;
    logic                     inst_valid_o;
    logic                     inst_stall_o;

    logic                     data_req_i;
    logic                     data_we_i;
    logic [ADDR_BITWIDTH-1:0] data_addr_i;
    logic [WORD_BITWIDTH-1:0] data_wdata_i;
    logic [WORD_BITWIDTH-1:0] data_rdata_o;
    logic                     data_valid_o;
    logic                     data_stall_o;

    logic                     mem_ce_o;
    logic                     mem_we_o;
    logic [ADDR_BITWIDTH-1:0] mem_addr_o;
    logic [WORD_BITWIDTH-1:0] mem_wdata_o;
    logic [WORD_BITWIDTH-1:0] mem_rdata_i;

    modport slave (
        input  inst_req_i, inst_addr_i, flush_i,
        input  data_req_i, data_we_i, data_addr_i, data_wdata_i,
        input  mem_rdata_i,
        output inst_rdata_o, inst_valid_o, inst_stall_o,
        output data_rdata_o, data_valid_o, data_stall_o,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output inst_req_i, inst_addr_i, flush_i,
        output data_req_i, data_we_i, data_addr_i, data_wdata_i,
        output mem_rdata_i,
        input  inst_rdata_o, inst_valid_o, inst_stall_o,
        input  data_rdata_o, data_valid_o, data_stall_o,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the instruction-fetch port and the
// load/store port. Each access runs IDLE -> ISSUE -> WAIT -> DONE and completes with a
// one-cycle valid pulse on the owning port; data wins ties unless the fetch port has been
// passed over STARVE_LIMIT times in a row.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if slave modport (fetch port, data port, memory port)
module mem_port_arbiter #(
    parameter int unsigned WORD_BITWIDTH = 32,
    parameter int unsigned ADDR_BITWIDTH = 32,
    parameter int unsigned MEM_LATENCY   = 2,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StvW-1:0] StarveMax = StvW'(STARVE_LIMIT);
    localparam logic [CntW-1:0] CntLoad   = CntW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;
    typedef enum logic [1:0] {OwnNone, OwnInst, OwnData} owner_t;

    state_t                   r_state;
    owner_t                   r_owner;
    logic [StvW-1:0]          r_starve_cnt;
    logic [CntW-1:0]          r_cnt;
    logic                     r_flush_pending;
    logic                     r_is_store;
    logic                     r_mem_ce;
    logic                     r_mem_we;
    logic [ADDR_BITWIDTH-1:0] r_mem_addr;
    logic [WORD_BITWIDTH-1:0] r_mem_wdata;
    logic [WORD_BITWIDTH-1:0] r_inst_rdata;
    logic [WORD_BITWIDTH-1:0] r_data_rdata;
    logic                     r_inst_valid;
    logic                     r_data_valid;

    logic w_inst_ok;
    logic w_grant_data;
    logic w_grant_inst;

    // A fetch under redirect is never granted; data yields only to a starved fetch.
    assign w_inst_ok    = bus.inst_req_i & ~bus.flush_i;
    assign w_grant_data = bus.data_req_i & ~(w_inst_ok & (r_starve_cnt == StarveMax));
    assign w_grant_inst = w_inst_ok & ~w_grant_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= StIdle;
            r_owner         <= OwnNone;
            r_starve_cnt    <= '0;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
            r_is_store      <= 1'b0;
            r_mem_ce        <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_inst_rdata    <= '0;
            r_data_rdata    <= '0;
            r_inst_valid    <= 1'b0;
            r_data_valid    <= 1'b0;
        end else begin
            if (r_state != StIdle && r_owner == OwnInst && bus.flush_i) begin
                r_flush_pending <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (w_grant_data) begin
                        r_owner     <= OwnData;
                        r_is_store  <= bus.data_we_i;
                        r_mem_ce    <= 1'b1;
                        r_mem_we    <= bus.data_we_i;
                        r_mem_addr  <= bus.data_addr_i;
                        r_mem_wdata <= bus.data_wdata_i;
                        r_state     <= StIssue;
                        if (bus.inst_req_i && r_starve_cnt != StarveMax) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (w_grant_inst) begin
                        r_owner      <= OwnInst;
                        r_is_store   <= 1'b0;
                        r_mem_ce     <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= bus.inst_addr_i;
                        r_mem_wdata  <= '0;
                        r_state      <= StIssue;
                        r_starve_cnt <= '0;
                    end
                    if (!bus.inst_req_i) begin
                        r_starve_cnt <= '0;
                    end
                end
                StIssue: begin
                    r_mem_ce <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_cnt    <= CntLoad;
                    r_state  <= StWait;
                end
                StWait: begin
                    if (r_cnt == '0) begin
                        if (r_owner == OwnInst) begin
                            r_inst_rdata <= bus.mem_rdata_i;
                            // A redirect arriving on this last cycle still kills the pulse.
                            r_inst_valid <= ~(r_flush_pending | bus.flush_i);
                        end else begin
                            if (!r_is_store) begin
                                r_data_rdata <= bus.mem_rdata_i;
                            end
                            r_data_valid <= 1'b1;
                        end
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDone: begin
                    r_inst_valid    <= 1'b0;
                    r_data_valid    <= 1'b0;
                    r_flush_pending <= 1'b0;
                    r_owner         <= OwnNone;
                    r_state         <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.mem_ce_o     = r_mem_ce;
    assign bus.mem_we_o     = r_mem_we;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_wdata_o  = r_mem_wdata;
    assign bus.inst_rdata_o = r_inst_rdata;
    assign bus.inst_valid_o = r_inst_valid;
    assign bus.data_rdata_o = r_data_rdata;
    assign bus.data_valid_o = r_data_valid;
    assign bus.inst_stall_o = bus.inst_req_i & ~r_inst_valid;
    assign bus.data_stall_o = bus.data_req_i & ~r_data_valid;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and its data (load/store) port.
- Sits between the pipeline's memory interfaces and a unified memory model.
- Arbitrates requests, sequences each access through a fixed-latency state machine, and returns data with a valid pulse.
- Drives per-port stall outputs so the pipeline freezes while its access is pending.

Parameters:
- WORD_BITWIDTH, 32, data width.
- ADDR_BITWIDTH, 32, address width.
- MEM_LATENCY, 2, cycles from mem_ce_o high to mem_rdata_i valid; legal range >=1.
- STARVE_LIMIT, 4, max consecutive data grants while inst_req_i is pending before inst is forced; legal range >=1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req_i  in  1  fetch request; held until inst_valid_o.
- inst_addr_i  in  ADDR_BITWIDTH  fetch address.
- flush_i  in  1  taken-branch redirect; discards the fetch.
- inst_rdata_o  out  WORD_BITWIDTH  fetched word.
- inst_valid_o  out  1  one-cycle completion pulse.
- inst_stall_o  out  1  fetch pending, freeze front end.
- data_req_i  in  1  load/store request; held until data_valid_o.
- data_we_i  in  1  1 = store.
- data_addr_i  in  ADDR_BITWIDTH  data address.
- data_wdata_i  in  WORD_BITWIDTH  store data.
- data_rdata_o  out  WORD_BITWIDTH  load data.
- data_valid_o  out  1  one-cycle completion pulse; also acks stores.
- data_stall_o  out  1  data access pending.
- mem_ce_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_BITWIDTH  memory address.
- mem_wdata_o  out  WORD_BITWIDTH  memory write data.
- mem_rdata_i  in  WORD_BITWIDTH  memory read data.

Behaviour:
- Reset (synchronous): state IDLE, owner=none, starve_cnt=0. All registered outputs 0: mem_*, *_rdata_o, *_valid_o. Reset mid-transaction abandons it; no valid pulse follows.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.

IDLE:
- Evaluate requests.
  - Only data_req_i: grant data.
  - Only inst_req_i and flush_i=0: grant inst.
  - Both: grant data unless starve_cnt==STARVE_LIMIT, in which case grant inst.
  - inst_req_i with flush_i=1 is not granted that cycle.
- On a grant: latch owner, addr, we, wdata into the mem_* registers; next state ISSUE.

ISSUE (exactly 1 cycle):
- mem_ce_o=1. mem_we_o=data_we_i for data owner, 0 for inst.
- Load cnt=MEM_LATENCY-1. Next state WAIT.

WAIT (MEM_LATENCY cycles):
- mem_ce_o=0, mem_we_o=0. Decrement cnt.
- When cnt==0: capture mem_rdata_i into the owner's rdata register (reads only; a store leaves data_rdata_o unchanged). Next state DONE.

DONE (1 cycle):
- Owner's valid_o=1, unless owner is inst and a flush was recorded.
- No grant is evaluated, so the still-asserted request is not re-accepted. Next state IDLE.

Latency:
- Request seen in IDLE at cycle R: mem_ce_o at R+1, valid at R+MEM_LATENCY+2.
- Back-to-back throughput: one access per MEM_LATENCY+3 cycles.

Stalls (combinational):
- inst_stall_o = inst_req_i & ~inst_valid_o.
- data_stall_o = data_req_i & ~data_valid_o.

Flush:
- flush_i in any non-IDLE state with owner=inst sets flush_pending.
- The transaction still completes on memory, but inst_valid_o is suppressed in DONE.
- flush_pending clears on leaving DONE.
- Flush never affects a data-owned transaction.

Starvation counter:
- starve_cnt increments, saturating at STARVE_LIMIT, on each data grant while inst_req_i=1.
- Clears on inst grant, or in any IDLE cycle with inst_req_i=0.

- rdata registers hold their last value between transactions.

Test Plan:
- Single load, MEM_LATENCY=2: data_req_i=1, addr=0x100 at cycle 0; memory returns 0xDEADBEEF -> mem_ce_o=1 at cycle 1 only; data_valid_o=1 and data_rdata_o=0xDEADBEEF at cycle 4; data_stall_o=1 cycles 0-3.
- Store: data_we_i=1, addr=0x20, wdata=0x55 -> mem_we_o=1, mem_wdata_o=0x55 at cycle 1; data_valid_o pulse at cycle 4; data_rdata_o unchanged.
- Simultaneous requests, STARVE_LIMIT=4: data_req_i held high continuously alongside inst_req_i -> four data grants, then the fifth grant goes to inst; starve_cnt returns to 0.
- Flush in flight: inst fetch granted at cycle 0, flush_i=1 at cycle 2 -> mem access still issued at cycle 1; inst_valid_o stays 0 at cycle 4; next inst request accepted at cycle 5.
- Flush in IDLE: inst_req_i=1 with flush_i=1 at cycle 0 -> no grant, mem_ce_o=0 at cycle 1; grant occurs at the next IDLE cycle with flush_i=0.
- Reset mid-WAIT: rst=1 at cycle 2 of a load -> cycle 3 all outputs 0, state IDLE; no valid pulse follows; a new request is served normally.
